// File: rtl/itch_msg_sequencer.sv
// Sequences the header parser's byte stream into whole ITCH 5.0 messages.
// It steers bytes to per-type decoders and flags truncated, unknown or interrupted messages.
module itch_msg_sequencer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_flag_in,
  input  logic [7:0]       payload_in,
  input  logic             payload_valid_in,
  output logic [7:0]       byte_out,
  output logic             byte_valid_out,
  output logic [IDX_W-1:0] byte_idx_out,
  output logic [5:0]       dec_en_out,
  output logic             msg_end_out,
  output logic             msg_err_out,
  output logic [1:0]       err_code_out,
  output logic [CNT_W-1:0] msg_count_out,
  output logic [CNT_W-1:0] err_count_out
);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             bv_q, bv_d;
  logic             end_q, end_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [5:0]       dec_q, dec_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  logic [5:0]       type_sel;
  logic [IDX_W-1:0] type_rem;
  logic             take_type;

  // Type table: rem is the byte count following the type byte.
  always_comb begin
    type_sel = '0;
    type_rem = '0;
    case (payload_in)
      8'h41: begin type_sel = 6'b000001; type_rem = IDX_W'(35); end
      8'h44: begin type_sel = 6'b000010; type_rem = IDX_W'(18); end
      8'h55: begin type_sel = 6'b000100; type_rem = IDX_W'(34); end
      8'h45: begin type_sel = 6'b001000; type_rem = IDX_W'(30); end
      8'h58: begin type_sel = 6'b010000; type_rem = IDX_W'(22); end
      8'h50: begin type_sel = 6'b100000; type_rem = IDX_W'(43); end
      default: begin type_sel = '0; type_rem = '0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    code_d    = code_q;
    bv_d      = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    dec_d     = '0;
    take_type = 1'b0;

    unique case (state_q)
      StIdle: take_type = payload_valid_in;
      StActive: begin
        if (!payload_valid_in) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = StIdle;
        end else if (start_flag_in) begin
          // Interrupted message is dropped; this byte opens the next one.
          err_d     = 1'b1;
          code_d    = 2'b11;
          take_type = 1'b1;
        end else begin
          bv_d   = 1'b1;
          byte_d = payload_in;
          idx_d  = idx_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          dec_d  = dec_q;
          if (rem_q == IDX_W'(1)) begin
            end_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        if (!payload_valid_in) begin
          state_d = StIdle;
        end else if (start_flag_in) begin
          take_type = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_type) begin
      if (|type_sel) begin
        bv_d    = 1'b1;
        byte_d  = payload_in;
        idx_d   = '0;
        rem_d   = type_rem;
        dec_d   = type_sel;
        state_d = StActive;
      end else begin
        // An interruption code outranks the unknown-type code on the same byte.
        err_d = 1'b1;
        if (state_q != StActive) code_d = 2'b01;
        state_d = StDrain;
      end
    end

    mcnt_d = (end_d && !(&mcnt_q)) ? mcnt_q + 1'b1 : mcnt_q;
    ecnt_d = (err_d && !(&ecnt_q)) ? ecnt_q + 1'b1 : ecnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      dec_q   <= '0;
      mcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      end_q   <= end_d;
      err_q   <= err_d;
      code_q  <= code_d;
      dec_q   <= dec_d;
      mcnt_q  <= mcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign byte_out       = byte_q;
  assign byte_valid_out = bv_q;
  assign byte_idx_out   = idx_q;
  assign dec_en_out     = dec_q;
  assign msg_end_out    = end_q;
  assign msg_err_out    = err_q;
  assign err_code_out   = code_q;
  assign msg_count_out  = mcnt_q;
  assign err_count_out  = ecnt_q;

endmodule
